// File: rtl/tri_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tri_arb_pkg
//  Description : Shared state encodings and width helper for tri_pin_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package tri_arb_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_turn = 2'd1;
    localparam logic [1:0] c_st_own  = 2'd2;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tri_pin_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin priority encoder; lowest set request
//                at or above ptr wins, otherwise wraps to the lowest set request.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick
    import tri_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = cnt_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx,
    output logic            any
);

    logic          w_any_hi;
    logic          w_any_all;
    logic [PW-1:0] w_idx_hi;
    logic [PW-1:0] w_idx_all;

    // Descending scan so the last hit written is the lowest index.
    always_comb begin
        w_any_hi  = 1'b0;
        w_any_all = 1'b0;
        w_idx_hi  = '0;
        w_idx_all = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_any_all = 1'b1;
                w_idx_all = PW'(i);
                if (PW'(i) >= ptr) begin
                    w_any_hi = 1'b1;
                    w_idx_hi = PW'(i);
                end
            end
        end
    end

    always_comb begin
        any    = w_any_all;
        idx    = w_any_hi ? w_idx_hi : w_idx_all;
        onehot = w_any_all ? (NREQ'(1) << idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/tri_pin_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tri_pin_arbiter
//  Description : Round-robin owner selection for one shared tristate pin with
//                released-pin turnaround cycles before every new grant.
//  Revision    : 1.0  initial release
// ============================================================================
module tri_pin_arbiter
    import tri_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] dout,
    output logic [NREQ-1:0] gnt,
    output logic            pin_out,
    output logic            pin_oe,
    input  logic            pin_in,
    output logic            din,
    output logic            busy
);

    localparam int c_pw = cnt_width(NREQ);
    localparam int c_tw = cnt_width(TURN_CYCLES);
    localparam int c_hw = cnt_width(MAX_HOLD);

    localparam logic [c_tw-1:0] c_turn_load = c_tw'(TURN_CYCLES - 1);
    localparam logic [c_hw-1:0] c_hold_max  = c_hw'(MAX_HOLD - 1);
    localparam logic [c_pw-1:0] c_last_req  = c_pw'(NREQ - 1);

    generate
        if (TURN_CYCLES < 1) begin : g_bad_turn
            $error("tri_pin_arbiter: TURN_CYCLES must be at least 1");
        end
        if (MAX_HOLD < 2) begin : g_bad_hold
            $error("tri_pin_arbiter: MAX_HOLD must be at least 2");
        end
        if ((NREQ < 2) || (NREQ > 8)) begin : g_bad_nreq
            $error("tri_pin_arbiter: NREQ must be in 2..8");
        end
    endgenerate

    logic [1:0]      r_state;
    logic [c_pw-1:0] r_rr_ptr;
    logic [c_pw-1:0] r_winner;
    logic [c_tw-1:0] r_turn_cnt;
    logic [c_hw-1:0] r_hold_cnt;
    logic [NREQ-1:0] r_gnt;
    logic            r_pin_out;
    logic            r_pin_oe;
    logic            r_din;

    logic [NREQ-1:0] w_pick_onehot;
    logic [c_pw-1:0] w_pick_idx;
    logic            w_pick_any;
    logic [NREQ-1:0] w_winner_onehot;
    logic [c_pw-1:0] w_next_ptr;
    logic            w_other_req;
    logic            w_release;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (c_pw)
    ) u_rr_pick (
        .req    (req),
        .ptr    (r_rr_ptr),
        .onehot (w_pick_onehot),
        .idx    (w_pick_idx),
        .any    (w_pick_any)
    );

    assign w_winner_onehot = NREQ'(1) << r_winner;
    assign w_next_ptr      = (r_winner == c_last_req) ? '0 : r_winner + 1'b1;
    assign w_other_req     = |(req & ~w_winner_onehot & w_pick_onehot | req & ~w_winner_onehot);
    // Dropping the request and hitting the hold limit collapse into one release.
    assign w_release       = !req[r_winner] || ((r_hold_cnt == c_hold_max) && w_other_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_rr_ptr   <= '0;
            r_winner   <= '0;
            r_turn_cnt <= '0;
            r_hold_cnt <= '0;
            r_gnt      <= '0;
            r_pin_out  <= 1'b0;
            r_pin_oe   <= 1'b0;
            r_din      <= 1'b0;
        end else begin
            r_din <= pin_in;
            case (r_state)
                c_st_idle: begin
                    if (w_pick_any) begin
                        r_winner   <= w_pick_idx;
                        r_turn_cnt <= c_turn_load;
                        r_state    <= c_st_turn;
                    end
                end
                c_st_turn: begin
                    if (r_turn_cnt == '0) begin
                        if (req[r_winner]) begin
                            r_state    <= c_st_own;
                            r_gnt      <= w_winner_onehot;
                            r_pin_oe   <= 1'b1;
                            r_pin_out  <= dout[r_winner];
                            r_hold_cnt <= '0;
                        end else begin
                            r_state  <= c_st_idle;
                            r_rr_ptr <= w_next_ptr;
                        end
                    end else begin
                        r_turn_cnt <= r_turn_cnt - 1'b1;
                    end
                end
                c_st_own: begin
                    if (w_release) begin
                        r_state   <= c_st_idle;
                        r_gnt     <= '0;
                        r_pin_oe  <= 1'b0;
                        r_pin_out <= 1'b0;
                        r_rr_ptr  <= w_next_ptr;
                    end else begin
                        r_pin_out <= dout[r_winner];
                        if (r_hold_cnt != c_hold_max) begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= c_st_idle;
                    r_gnt     <= '0;
                    r_pin_oe  <= 1'b0;
                    r_pin_out <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign pin_out = r_pin_out;
    assign pin_oe  = r_pin_oe;
    assign din     = r_din;
    assign busy    = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_tri_pin_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tri_pin_arbiter
//  Description : Directed scenarios plus random traffic against a cycle-level
//                reference model of the shared-pin arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tri_pin_arbiter;

    localparam int c_nreq = 4;
    localparam int c_turn = 1;
    localparam int c_hold = 16;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [3:0] req    = '0;
    logic [3:0] dout   = '0;
    logic       pin_in = 1'b0;
    logic [3:0] gnt;
    logic       pin_out;
    logic       pin_oe;
    logic       din;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    tri_pin_arbiter #(
        .NREQ        (c_nreq),
        .TURN_CYCLES (c_turn),
        .MAX_HOLD    (c_hold)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .dout    (dout),
        .gnt     (gnt),
        .pin_out (pin_out),
        .pin_oe  (pin_oe),
        .pin_in  (pin_in),
        .din     (din),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = pin free, 1 = turnaround, 2 = owned.
    int   m_mode, m_ptr, m_owner, m_turn_left, m_held;
    logic e_out, e_din;

    int         cyc = 0;
    int         last_fall;
    bit         have_fall;
    logic       prev_oe;
    logic [3:0] prev_gnt;
    int         grant_len;
    int         owner_log[$];
    int         len_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int first_from(input logic [3:0] r, input int start);
        for (int k = 0; k < c_nreq; k++) begin
            if (r[(start + k) % c_nreq]) return (start + k) % c_nreq;
        end
        return -1;
    endfunction

    function automatic int bit_index(input logic [3:0] v);
        for (int k = 0; k < c_nreq; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode      = 0;
        m_ptr       = 0;
        m_owner     = 0;
        m_turn_left = 0;
        m_held      = 0;
        e_out       = 1'b0;
        e_din       = 1'b0;
        prev_oe     = 1'b0;
        prev_gnt    = '0;
        have_fall   = 0;
        grant_len   = 0;
    endtask

    // Predicts the outputs after the coming rising edge from the inputs now applied.
    task automatic model_step();
        logic [3:0] mask;
        bit         other;
        e_din = pin_in;
        case (m_mode)
            0: begin
                if (req != 4'b0000) begin
                    m_owner     = first_from(req, m_ptr);
                    m_turn_left = c_turn;
                    m_mode      = 1;
                end
            end
            1: begin
                m_turn_left--;
                if (m_turn_left == 0) begin
                    if (req[m_owner]) begin
                        m_mode = 2;
                        m_held = 0;
                        e_out  = dout[m_owner];
                    end else begin
                        m_mode = 0;
                        m_ptr  = (m_owner + 1) % c_nreq;
                    end
                end
            end
            default: begin
                m_held++;
                mask  = 4'b0001 << m_owner;
                other = ((req & ~mask) != 4'b0000);
                if (!req[m_owner] || (m_held >= c_hold && other)) begin
                    m_mode = 0;
                    e_out  = 1'b0;
                    m_ptr  = (m_owner + 1) % c_nreq;
                end else begin
                    e_out = dout[m_owner];
                end
            end
        endcase
    endtask

    task automatic compare();
        logic [3:0] e_gnt;
        cyc++;
        e_gnt = (m_mode == 2) ? 4'(1 << m_owner) : 4'b0000;
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("pin_oe", 32'(pin_oe), 32'(m_mode == 2));
        check("pin_out", 32'(pin_out), 32'(e_out));
        check("din", 32'(din), 32'(e_din));
        check("busy", 32'(busy), 32'(m_mode != 0));
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        check("oe_matches_gnt", 32'(pin_oe), 32'(|gnt));
        if (prev_oe === 1'b1 && pin_oe === 1'b0) begin
            last_fall = cyc;
            have_fall = 1;
        end
        if (prev_oe === 1'b0 && pin_oe === 1'b1 && have_fall)
            check("oe_turn_gap", 32'((cyc - last_fall) > c_turn), 32'd1);
        if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
            owner_log.push_back(bit_index(gnt));
            grant_len = 0;
        end
        if (gnt != 4'b0000) grant_len++;
        if (gnt == 4'b0000 && prev_gnt != 4'b0000) len_log.push_back(grant_len);
        prev_oe  = pin_oe;
        prev_gnt = gnt;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        compare();
    endtask

    // Reset asserted between edges; outputs must fall without a clock.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_oe", 32'(pin_oe), 32'd0);
        check("async_rst_gnt", 32'(gnt), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit seen;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        compare();

        // Single requester: grant two edges after the request.
        req = 4'b0010;
        tick();
        tick();
        check("s1_gnt", 32'(gnt), 32'h2);
        check("s1_oe", 32'(pin_oe), 32'd1);
        for (int i = 0; i < 6; i++) begin
            dout   = 4'($urandom());
            pin_in = 1'($urandom());
            tick();
        end

        // Reset mid-ownership, then full contention rotates from requester 0.
        async_reset();
        owner_log.delete();
        len_log.delete();
        req = 4'b1111;
        for (int i = 0; i < 95; i++) begin
            dout   = 4'($urandom());
            pin_in = 1'($urandom());
            tick();
        end
        for (int k = 0; k < 5; k++)
            check("s2_owner_order", 32'((k < owner_log.size()) ? owner_log[k] : -1), 32'(k % c_nreq));
        for (int k = 0; k < 4; k++)
            check("s2_grant_len", 32'((k < len_log.size()) ? len_log[k] : -1), 32'(c_hold));
        req = 4'b0000;
        repeat (4) tick();

        // Lone requester is never preempted.
        req = 4'b0100;
        repeat (3) tick();
        ok = 1;
        for (int i = 0; i < 100; i++) begin
            dout = 4'($urandom());
            tick();
            if (pin_oe !== 1'b1 || gnt !== 4'b0100) ok = 0;
        end
        check("s3_held_continuously", 32'(ok), 32'd1);
        req = 4'b0000;
        repeat (3) tick();

        // Request abandoned during turnaround yields no grant.
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        check("s4_abandon_idle", 32'(busy), 32'd0);
        check("s4_abandon_gnt", 32'(gnt), 32'd0);
        req = 4'b0101;
        tick();
        tick();
        check("s4_next_owner", 32'(gnt), 32'h1);
        req = 4'b0000;
        repeat (3) tick();

        // Owner drops exactly when its hold limit is reached with req[3] pending.
        async_reset();
        owner_log.delete();
        len_log.delete();
        req  = 4'b1001;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (gnt == 4'b0001) seen = 1;
        end
        check("s6_first_grant", 32'(seen), 32'd1);
        repeat (c_hold - 1) tick();
        req = 4'b1000;
        tick();
        check("s6_released", 32'(gnt), 32'd0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (gnt != 4'b0000) seen = 1;
        end
        check("s6_next_grant", 32'(gnt), 32'h8);
        check("s6_hold_len", 32'((len_log.size() > 0) ? len_log[0] : -1), 32'(c_hold));

        // Random traffic with occasional request toggles.
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < c_nreq; b++) begin
                if ($urandom_range(11) == 0) req[b] = ~req[b];
            end
            dout   = 4'($urandom());
            pin_in = 1'($urandom());
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
